// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  typedef enum logic [2:0] {
    DATA,
    PAD80,
    ZERO,
    LENHI,
    LENLO
  } state_t;

  localparam logic [7:0] PAD_BYTE        = 8'h80;
  localparam int         WORDS_PER_BLOCK = 16;
  localparam logic [3:0] LEN_HI_IDX      = 4'd14;
  localparam logic [3:0] LEN_LO_IDX      = 4'd15;

endpackage

// File: rtl/sha256_padder_if.sv
// Byte-input / word-output bus between the message source, the padder and the SHA-256 core.
interface sha256_padder_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic [3:0]  w_idx;
  logic        w_block_last;
  logic        w_msg_last;
  logic        busy;

  modport master (
    output in_data, in_valid, in_last, w_ready,
    input  in_ready, w_data, w_valid, w_idx, w_block_last, w_msg_last, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, w_ready,
    output in_ready, w_data, w_valid, w_idx, w_block_last, w_msg_last, busy
  );
endinterface

// File: rtl/sha256_byte_packer.sv
// Assembles accepted bytes big-endian into 32-bit words, inserting 0x80 after a short final word.
module sha256_byte_packer
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  output logic [31:0] o_word,
  output logic        o_emit,
  output logic        o_full_last
);

  logic [31:0] r_acc;
  logic [1:0]  r_pos;
  logic [31:0] w_word;

  // Lanes below the current byte are always zero in r_acc, so only the pad lane needs writing.
  always_comb begin
    w_word = r_acc;
    case (r_pos)
      2'd0: begin
        w_word[31:24] = i_data;
        if (i_last) w_word[23:16] = PAD_BYTE;
      end
      2'd1: begin
        w_word[23:16] = i_data;
        if (i_last) w_word[15:8] = PAD_BYTE;
      end
      2'd2: begin
        w_word[15:8] = i_data;
        if (i_last) w_word[7:0] = PAD_BYTE;
      end
      default: w_word[7:0] = i_data;
    endcase
  end

  assign o_word      = w_word;
  assign o_emit      = i_accept && ((r_pos == 2'd3) || i_last);
  assign o_full_last = i_accept && i_last && (r_pos == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_pos <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_pos <= '0;
    end else if (i_accept) begin
      if (o_emit) begin
        r_acc <= '0;
        r_pos <= '0;
      end else begin
        r_acc <= w_word;
        r_pos <= r_pos + 2'd1;
      end
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: byte stream in, 16-word padded blocks out with 64-bit bit length trailer.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  sha256_padder_if.slave  bus
);

  state_t            r_state;
  logic [LEN_W-1:0]  r_byte_cnt;
  logic [3:0]        r_idx;
  logic              r_wvalid;
  logic [31:0]       r_wdata;
  logic              r_block_last;
  logic              r_msg_last;

  logic              w_accept;
  logic              w_hs;
  logic              w_slot;
  logic [3:0]        w_nidx;
  state_t            w_pad_next;
  logic [63:0]       w_bitlen;
  logic [31:0]       w_pk_word;
  logic              w_pk_emit;
  logic              w_pk_full_last;

  assign bus.in_ready     = (r_state == DATA) && !r_wvalid;
  assign bus.w_data       = r_wdata;
  assign bus.w_valid      = r_wvalid;
  assign bus.w_idx        = r_idx;
  assign bus.w_block_last = r_block_last;
  assign bus.w_msg_last   = r_msg_last;
  assign bus.busy         = (r_state != DATA) || (r_byte_cnt != '0) || r_wvalid;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_hs     = r_wvalid && bus.w_ready;
  assign w_slot   = !r_wvalid || w_hs;
  assign w_nidx   = w_hs ? r_idx + 4'd1 : r_idx;
  assign w_bitlen = 64'({r_byte_cnt, 3'b000});

  // Deciding ZERO vs LENHI at emission time keeps pad words back to back with no idle cycle.
  assign w_pad_next = ((w_nidx + 4'd1) == LEN_HI_IDX) ? LENHI : ZERO;

  sha256_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (clear),
    .i_accept    (w_accept),
    .i_data      (bus.in_data),
    .i_last      (bus.in_last),
    .o_word      (w_pk_word),
    .o_emit      (w_pk_emit),
    .o_full_last (w_pk_full_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= DATA;
      r_byte_cnt   <= '0;
      r_idx        <= '0;
      r_wvalid     <= 1'b0;
      r_wdata      <= '0;
      r_block_last <= 1'b0;
      r_msg_last   <= 1'b0;
    end else if (clear) begin
      r_state      <= DATA;
      r_byte_cnt   <= '0;
      r_idx        <= '0;
      r_wvalid     <= 1'b0;
      r_wdata      <= '0;
      r_block_last <= 1'b0;
      r_msg_last   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_idx        <= r_idx + 4'd1;
        r_wvalid     <= 1'b0;
        r_block_last <= 1'b0;
        r_msg_last   <= 1'b0;
      end
      case (r_state)
        DATA: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + LEN_W'(1);
            if (bus.in_last) r_state <= w_pk_full_last ? PAD80 : w_pad_next;
          end
          if (w_pk_emit) begin
            r_wvalid     <= 1'b1;
            r_wdata      <= w_pk_word;
            r_block_last <= (w_nidx == LEN_LO_IDX);
            r_msg_last   <= 1'b0;
          end
        end
        PAD80: if (w_slot) begin
          r_wvalid     <= 1'b1;
          r_wdata      <= {PAD_BYTE, 24'h0};
          r_block_last <= (w_nidx == LEN_LO_IDX);
          r_msg_last   <= 1'b0;
          r_state      <= w_pad_next;
        end
        ZERO: if (w_slot) begin
          r_wvalid     <= 1'b1;
          r_wdata      <= '0;
          r_block_last <= (w_nidx == LEN_LO_IDX);
          r_msg_last   <= 1'b0;
          r_state      <= w_pad_next;
        end
        LENHI: if (w_slot) begin
          r_wvalid     <= 1'b1;
          r_wdata      <= w_bitlen[63:32];
          r_block_last <= 1'b0;
          r_msg_last   <= 1'b0;
          r_state      <= LENLO;
        end
        LENLO: if (w_slot) begin
          r_wvalid     <= 1'b1;
          r_wdata      <= w_bitlen[31:0];
          r_block_last <= 1'b1;
          r_msg_last   <= 1'b1;
          r_byte_cnt   <= '0;
          r_state      <= DATA;
        end
        default: r_state <= DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized self-checking bench for sha256_padder against a byte-level padding model.
module tb_sha256_padder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  sha256_padder_if bus ();

  sha256_padder #(.LEN_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;

  // 0: manual (man_rdy), 1: always ready, 2: random ready
  int   ready_mode = 1;
  logic man_rdy = 1'b0;
  logic rnd_rdy = 1'b1;
  assign bus.w_ready = (ready_mode == 0) ? man_rdy : (ready_mode == 1) ? 1'b1 : rnd_rdy;

  always @(posedge clk) begin
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  logic [31:0] cap_d[$];
  logic [3:0]  cap_i[$];
  logic        cap_bl[$];
  logic        cap_ml[$];
  logic [31:0] exp_w[$];

  // A handshake seen at the falling edge completes at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && !clear && bus.w_valid && bus.w_ready) begin
      cap_d.push_back(bus.w_data);
      cap_i.push_back(bus.w_idx);
      cap_bl.push_back(bus.w_block_last);
      cap_ml.push_back(bus.w_msg_last);
    end
  end

  task automatic flush_capture();
    cap_d.delete();
    cap_i.delete();
    cap_bl.delete();
    cap_ml.delete();
  endtask

  // Reference: message, 0x80, zeros to 56 mod 64, then 64-bit big-endian bit length.
  task automatic build_expected(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [63:0] bitlen;
    p = m;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bitlen = 64'(m.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
    exp_w.delete();
    for (int j = 0; j < p.size(); j += 4) exp_w.push_back({p[j], p[j+1], p[j+2], p[j+3]});
  endtask

  task automatic send_msg(input logic [7:0] m[$], input int gap_max, output bit ok);
    bit acc;
    int guard;
    ok = 1'b1;
    for (int i = 0; i < m.size(); i++) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = m[i];
      bus.in_last  = (i == m.size() - 1);
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 3000) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        ok = 1'b0;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_words(input int n, output bit ok);
    int c = 0;
    while (cap_d.size() < n && c < 20000) begin
      @(posedge clk);
      #1;
      c++;
    end
    ok = (cap_d.size() >= n);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic drive_msg(input logic [7:0] m[$], input int gap_max, output bit ok);
    bit ok_s, ok_w;
    build_expected(m);
    flush_capture();
    fork
      send_msg(m, gap_max, ok_s);
      wait_words(exp_w.size(), ok_w);
    join
    ok = ok_s && ok_w;
  endtask

  function automatic void abc_msg(output logic [7:0] m[$]);
    m.delete();
    m.push_back(8'h61);
    m.push_back(8'h62);
    m.push_back(8'h63);
  endfunction

  function automatic void seq_msg(input int n, output logic [7:0] m[$]);
    m.delete();
    for (int i = 0; i < n; i++) m.push_back(8'(i));
  endfunction

  task automatic test_reset();
    tot++; if (bus.w_valid !== 1'b0)      begin bad++; $display("FAIL reset_w_valid got=%b exp=0", bus.w_valid); end
    tot++; if (bus.in_ready !== 1'b1)     begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    tot++; if (bus.busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tot++; if (bus.w_idx !== 4'd0)        begin bad++; $display("FAIL reset_w_idx got=%0d exp=0", bus.w_idx); end
    tot++; if (bus.w_data !== 32'h0)      begin bad++; $display("FAIL reset_w_data got=%h exp=0", bus.w_data); end
    tot++; if (bus.w_block_last !== 1'b0) begin bad++; $display("FAIL reset_block_last got=%b exp=0", bus.w_block_last); end
    tot++; if (bus.w_msg_last !== 1'b0)   begin bad++; $display("FAIL reset_msg_last got=%b exp=0", bus.w_msg_last); end
  endtask

  task automatic test_fixed(input int n, input string name);
    logic [7:0] m[$];
    bit ok;
    logic [3:0] ei;
    logic ebl, eml;
    if (n == 3) abc_msg(m); else seq_msg(n, m);
    ready_mode = 1;
    drive_msg(m, 0, ok);
    tot++; if (!ok) begin bad++; $display("FAIL %s_timeout got=%0d words exp=%0d", name, cap_d.size(), exp_w.size()); end
    tot++; if (cap_d.size() != exp_w.size()) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, cap_d.size(), exp_w.size()); end
    for (int j = 0; j < exp_w.size(); j++) begin
      ei  = 4'(j % 16);
      ebl = (ei == 4'd15);
      eml = (j == exp_w.size() - 1);
      tot++;
      if ({cap_d[j], cap_i[j], cap_bl[j], cap_ml[j]} !== {exp_w[j], ei, ebl, eml}) begin
        bad++;
        $display("FAIL %s_word%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", name, j,
                 cap_d[j], cap_i[j], cap_bl[j], cap_ml[j], exp_w[j], ei, ebl, eml);
      end
    end
    tot++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL %s_idle got busy=%b in_ready=%b exp busy=0 in_ready=1", name, bus.busy, bus.in_ready); end
  endtask

  task automatic test_known_vectors();
    test_fixed(3, "abc");
    tot++; if (cap_d[0] !== 32'h61626380) begin bad++; $display("FAIL abc_w0 got=%h exp=61626380", cap_d[0]); end
    tot++; if (cap_d[15] !== 32'h18 || cap_ml[15] !== 1'b1) begin bad++; $display("FAIL abc_len got=%h/%b exp=00000018/1", cap_d[15], cap_ml[15]); end
    test_fixed(55, "b55");
    tot++; if (cap_d.size() != 16 || cap_d[13] !== 32'h34353680) begin bad++; $display("FAIL b55_w13 got=%h n=%0d exp=34353680 n=16", cap_d[13], cap_d.size()); end
    tot++; if (cap_d[15] !== 32'h1B8) begin bad++; $display("FAIL b55_len got=%h exp=000001b8", cap_d[15]); end
    test_fixed(56, "b56");
    tot++; if (cap_d[14] !== 32'h80000000) begin bad++; $display("FAIL b56_pad got=%h exp=80000000", cap_d[14]); end
    tot++; if (cap_bl[15] !== 1'b1 || cap_ml[15] !== 1'b0) begin bad++; $display("FAIL b56_blk1 got=bl%b ml%b exp=bl1 ml0", cap_bl[15], cap_ml[15]); end
    tot++; if (cap_d.size() != 32 || cap_d[31] !== 32'h1C0) begin bad++; $display("FAIL b56_len got=%h n=%0d exp=000001c0 n=32", cap_d[31], cap_d.size()); end
    test_fixed(64, "b64");
    tot++; if (cap_d[16] !== 32'h80000000) begin bad++; $display("FAIL b64_pad got=%h exp=80000000", cap_d[16]); end
    tot++; if (cap_bl[15] !== 1'b1 || cap_ml[15] !== 1'b0) begin bad++; $display("FAIL b64_blk1 got=bl%b ml%b exp=bl1 ml0", cap_bl[15], cap_ml[15]); end
    tot++; if (cap_d[31] !== 32'h200) begin bad++; $display("FAIL b64_len got=%h exp=00000200", cap_d[31]); end
  endtask

  task automatic hold_check(input string name);
    logic [31:0] d0;
    logic [3:0]  i0;
    d0 = bus.w_data;
    i0 = bus.w_idx;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2;
      tot++;
      if (bus.w_valid !== 1'b1 || bus.w_data !== d0 || bus.w_idx !== i0 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_hold%0d got=%b/%h/%0d/rdy%b exp=1/%h/%0d/rdy0", name, k,
                 bus.w_valid, bus.w_data, bus.w_idx, bus.in_ready, d0, i0);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] m[$];
    bit ok_s, ok_w;
    int c;
    abc_msg(m);
    build_expected(m);
    flush_capture();
    ready_mode = 0;
    man_rdy    = 1'b0;
    fork
      send_msg(m, 0, ok_s);
      begin
        c = 0;
        while (!bus.w_valid && c < 200) begin @(posedge clk); #2; c++; end
        tot++; if (bus.w_idx !== 4'd0 || bus.w_data !== 32'h61626380) begin bad++; $display("FAIL bp_first got=%h/%0d exp=61626380/0", bus.w_data, bus.w_idx); end
        hold_check("bp_idx0");
        man_rdy = 1'b1;
        c = 0;
        do begin @(posedge clk); #2; c++; end while (!(bus.w_valid && bus.w_idx == 4'd7) && c < 200);
        man_rdy = 1'b0;
        tot++; if (bus.w_idx !== 4'd7) begin bad++; $display("FAIL bp_reach7 got=%0d exp=7", bus.w_idx); end
        hold_check("bp_idx7");
        man_rdy = 1'b1;
        wait_words(exp_w.size(), ok_w);
      end
    join
    tot++; if (!(ok_s && ok_w)) begin bad++; $display("FAIL bp_timeout got=%0d words exp=%0d", cap_d.size(), exp_w.size()); end
    tot++; if (cap_d.size() != exp_w.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", cap_d.size(), exp_w.size()); end
    for (int j = 0; j < exp_w.size(); j++) begin
      tot++;
      if (cap_d[j] !== exp_w[j] || cap_i[j] !== 4'(j) || cap_ml[j] !== (j == 15)) begin
        bad++;
        $display("FAIL bp_word%0d got=%h/%0d/%b exp=%h/%0d/%b", j, cap_d[j], cap_i[j], cap_ml[j], exp_w[j], j, j == 15);
      end
    end
    ready_mode = 1;
  endtask

  task automatic test_clear();
    logic [7:0] m[$];
    bit ok;
    int c;
    abc_msg(m);
    ready_mode = 1;
    flush_capture();
    send_msg(m, 0, ok);
    c = 0;
    while (!(bus.w_valid && bus.w_idx == 4'd5) && c < 200) begin @(posedge clk); #2; c++; end
    tot++; if (bus.w_idx !== 4'd5) begin bad++; $display("FAIL clr_reach5 got=%0d exp=5", bus.w_idx); end
    clear = 1'b1;
    @(posedge clk);
    #2;
    tot++; if (bus.w_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.w_idx !== 4'd0) begin
      bad++;
      $display("FAIL clr_state got=v%b b%b r%b i%0d exp=v0 b0 r1 i0", bus.w_valid, bus.busy, bus.in_ready, bus.w_idx);
    end
    clear = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_fixed(3, "clr_abc");
  endtask

  task automatic test_random();
    logic [7:0] m[$];
    bit ok;
    int n;
    logic [3:0] ei;
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, 140);
      m.delete();
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      ready_mode = (t % 3 == 0) ? 1 : 2;
      drive_msg(m, t % 4, ok);
      tot++; if (!ok) begin bad++; $display("FAIL rnd%0d_timeout len=%0d got=%0d exp=%0d", t, n, cap_d.size(), exp_w.size()); end
      tot++; if (cap_d.size() != exp_w.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", t, cap_d.size(), exp_w.size()); end
      for (int j = 0; j < exp_w.size(); j++) begin
        ei = 4'(j % 16);
        tot++;
        if ({cap_d[j], cap_i[j], cap_bl[j], cap_ml[j]} !== {exp_w[j], ei, ei == 4'd15, j == exp_w.size() - 1}) begin
          bad++;
          $display("FAIL rnd%0d_word%0d got=%h/%0d/%b/%b exp=%h/%0d", t, j, cap_d[j], cap_i[j], cap_bl[j], cap_ml[j], exp_w[j], ei);
        end
      end
    end
    ready_mode = 1;
  endtask

  task automatic test_back_to_back();
    ready_mode = 1;
    for (int n = 1; n <= 5; n++) test_fixed(n, "b2b");
    test_fixed(60, "b2b60");
    test_fixed(63, "b2b63");
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_clear();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
